dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_pkg.sv | 30 +++
 rtl/dm_responder_if.sv | 34 +++
 rtl/dm_ram_array.sv | 29 ++
 rtl/dm_responder.sv | 134 +++++++++++++
 tb/tb_dm_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
`default_nettype none
// =====================================================================
// dm_responder_pkg : shared defaults, FSM encoding and wait-load helper
// Revision 1.0 - initial release
// =====================================================================
package dm_responder_pkg;

    localparam int unsigned DM_ADDR_W_DEF  = 8;
    localparam int unsigned DM_DATA_W_DEF  = 8;
    localparam int unsigned DM_WAIT_DEF    = 1;
    localparam int unsigned DM_WAIT_MAX    = 15;
    localparam int unsigned DM_WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dm_state_e;

    // Out-of-range wait requests saturate rather than silently truncate.
    function automatic logic [DM_WAIT_CNT_W-1:0] dm_wait_load(input int unsigned cycles);
        if (cycles > DM_WAIT_MAX) begin
            return DM_WAIT_CNT_W'(DM_WAIT_MAX);
        end
        return DM_WAIT_CNT_W'(cycles);
    endfunction

endpackage : dm_responder_pkg
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// =====================================================================
// dm_responder_if : request/response bus between requester and responder
// Revision 1.0 - initial release
// =====================================================================
interface dm_responder_if
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W_DEF,
    parameter int unsigned DATA_W = DM_DATA_W_DEF
);

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );

endinterface : dm_responder_if
`default_nettype wire

// File: rtl/dm_ram_array.sv
`default_nettype none
// =====================================================================
// dm_ram_array : single-port register array, sync write / comb read
// Revision 1.0 - initial release
// =====================================================================
module dm_ram_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  wire logic              clk_i,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // No reset: contents are cleared by the owner's INIT sweep.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : dm_ram_array
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// =====================================================================
// dm_responder : memory-backed responder with init clear and read waits
// Revision 1.0 - initial release
// =====================================================================
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DM_ADDR_W_DEF,
    parameter int unsigned DATA_W      = DM_DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = DM_WAIT_DEF
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    dm_responder_if.slave  bus
);

    localparam logic [ADDR_W-1:0]        ADDR_LAST = '1;
    localparam logic [DM_WAIT_CNT_W-1:0] WAIT_LOAD = dm_wait_load(WAIT_CYCLES);

    dm_state_e                state_q, state_d;
    logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [DM_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;

    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

    // RAM port steering is kept apart from the FSM so the read path has no loop.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        unique case (state_q)
            ST_INIT: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
            end
            ST_IDLE: begin
                ram_addr  = bus.req_addr;
                ram_we    = bus.req_valid & bus.req_we;
                ram_wdata = bus.req_wdata;
            end
            default: begin
                ram_addr = addr_q;
            end
        endcase
    end

    dm_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            ST_INIT: begin
                if (clr_cnt_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.req_valid && !bus.req_we) begin
                    addr_d = bus.req_addr;
                    if (WAIT_LOAD == '0) begin
                        // Zero-wait build: RAM is addressed by req_addr this cycle.
                        state_d = ST_RESP;
                        rdata_d = ram_rdata;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q <= DM_WAIT_CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    wait_cnt_d = '0;
                    rdata_d    = ram_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - DM_WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.init_done = (state_q != ST_INIT);

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// =====================================================================
// tb_dm_responder : directed bench for dm_responder (1-wait and 0-wait)
// Revision 1.0 - initial release
// =====================================================================
module tb_dm_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dm_responder_if #(.ADDR_W(8), .DATA_W(8)) bus  ();
    dm_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

    dm_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    dm_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    // Issues a read and returns latency (cycles from acceptance) and first valid data.
    task automatic start_read(input logic [7:0] a, output int lat, output logic seen,
                              output logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        d    = 8'h00;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                d    = bus.rsp_rdata;
            end else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic wait_init(output int bad_ready, output int bad_rsp);
        bad_ready = 0;
        bad_rsp   = 0;
        for (int i = 0; i < 256; i++) begin
            if (bus.req_ready !== 1'b0 || bus.init_done !== 1'b0) bad_ready++;
            if (bus.rsp_valid !== 1'b0 || bus0.rsp_valid !== 1'b0) bad_rsp++;
            tick();
        end
    endtask

    task automatic test_reset;
        int bad_ready, bad_rsp;
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h11;
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 00", bus.rsp_rdata); end
        checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b expected 0", bus.init_done); end
        rst_n = 1'b1;
        wait_init(bad_ready, bad_rsp);
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL init_busy_cycles: got %0d bad cycles expected 0", bad_ready); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL init_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", bus.init_done); end
        checks++; if (bus0.init_done !== 1'b1) begin errors++; $display("FAIL init_done_w0: got %b expected 1", bus0.init_done); end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_read_zero;
        int lat; logic seen; logic [7:0] d;
        start_read(8'h5A, lat, seen, d);
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL rd5a_latency: got %0d (seen %b) expected 2", lat, seen); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd5a_data: got %h expected 00", d); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd5a_rsp_done: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rd5a_rdata_idle: got %h expected 00", bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rd5a_back_idle: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_write_read;
        int lat; logic seen; logic [7:0] d;
        do_write(8'hFF, 8'hC3);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_stay_idle: got %b expected 1", bus.req_ready); end
        start_read(8'hFF, lat, seen, d);
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL rdff_latency: got %0d (seen %b) expected 2", lat, seen); end
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rdff_data: got %h expected c3", d); end
        tick();
    endtask

    task automatic test_backpressure;
        int lat; logic seen; logic [7:0] d; int held;
        do_write(8'h10, 8'h77);
        bus.rsp_ready = 1'b0;
        start_read(8'h10, lat, seen, d);
        held = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid === 1'b1 && bus.rsp_rdata === 8'h77 && bus.req_ready === 1'b0) held++;
            if (k == 0) begin
                // A write offered while busy must be ignored.
                bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h20; bus.req_wdata = 8'hEE;
            end
            if (k < 4) tick();
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        checks++; if (held != 5) begin errors++; $display("FAIL bp_hold: got %0d held cycles expected 5", held); end
        bus.rsp_ready = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL bp_rdata_zero: got %h expected 00", bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got %b expected 1", bus.req_ready); end
        start_read(8'h20, lat, seen, d);
        checks++; if (!seen || d !== 8'h00) begin errors++; $display("FAIL ignored_write: got %h (seen %b) expected 00", d, seen); end
        tick();
    endtask

    task automatic test_reset_mid_read;
        int lat; logic seen; logic [7:0] d; int bad_ready, bad_rsp;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'hFF;
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_wait_state: got %b expected 0", bus.rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.init_done !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_async_rst: got done=%b ready=%b expected 0 0", bus.init_done, bus.req_ready); end
        tick();
        rst_n = 1'b1;
        wait_init(bad_ready, bad_rsp);
        checks++; if (bad_rsp !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d response cycles expected 0", bad_rsp); end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL mid_reinit: got %b expected 1", bus.init_done); end
        start_read(8'hFF, lat, seen, d);
        checks++; if (!seen || d !== 8'h00) begin errors++; $display("FAIL mid_cleared: got %h (seen %b) expected 00", d, seen); end
        tick();
    endtask

    task automatic test_wait0;
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 8'h01;
        bus0.req_wdata = 8'h5C;
        tick();
        bus0.req_we = 1'b0;
        tick();
        bus0.req_valid = 1'b0;
        checks++; if (bus0.rsp_valid !== 1'b1) begin errors++; $display("FAIL w0_latency: got %b expected 1", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 8'h5C) begin errors++; $display("FAIL w0_data: got %h expected 5c", bus0.rsp_rdata); end
        tick();
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 8'h00) begin errors++; $display("FAIL w0_done: got v=%b d=%h expected 0 00", bus0.rsp_valid, bus0.rsp_rdata); end
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL w0_idle: got %b expected 1", bus0.req_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = 8'h00; bus.req_wdata  = 8'h00; bus.rsp_ready  = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 8'h00; bus0.req_wdata = 8'h00; bus0.rsp_ready = 1'b1;
        test_reset();
        test_read_zero();
        test_write_read();
        test_backpressure();
        test_reset_mid_read();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dm_responder
`default_nettype wire
